turn_executor: RTL and testbench
================================

TURN_EXECUTOR -- requirements
Module: turn_executor

Interface
REQ-001 SHALL have parameter CROSS_CYCLES, default 5000: cycles driven straight after node entry before any turn.
REQ-002 SHALL have parameter SPIN_MIN_CYCLES, default 2000: cycles of spin during which the line sensor is ignored.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000: spin cycle limit (used only with TURN_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run permission; low forces IDLE.
REQ-007 SHALL have port line_sensor  input  3  bit2=left, bit1=centre, bit0=right; 1 = on line.
REQ-008 SHALL have port turn_direction  input  2  upstream turn command: 01 LEFT, 10 RIGHT, 11 STRAIGHT, 00 treated as STRAIGHT.
REQ-009 SHALL have port arrived  input  1  upstream end-of-path flag.
REQ-010 SHALL have port motor_l  output  2  left wheel command: 00 stop, 01 forward, 10 reverse.
REQ-011 SHALL have port motor_r  output  2  right wheel command, same encoding.
REQ-012 SHALL have port busy  output  1  high in CROSS or SPIN.
REQ-013 SHALL have port turn_done  output  1  one-cycle pulse on return to FOLLOW after a node.
REQ-014 SHALL have port fault  output  1  spin timeout flag.

Function
REQ-015 SHALL implement states IDLE, FOLLOW, CROSS, SPIN, STOP, FAULT; all outputs registered.
REQ-016 IDLE: motors 00/00; go to FOLLOW when enable=1.
REQ-017 FOLLOW steering, by line_sensor: 010 -> 01/01; 100 or 110 -> 00/01; 001 or 011 -> 01/00; 000 or 101 -> hold previous motor commands.
REQ-018 Node = rising edge of (line_sensor==111), registered compare; in FOLLOW it moves to CROSS on the next edge.
REQ-019 On the first CROSS cycle SHALL latch turn_direction and sample arrived; upstream updates both on the node-detect edge.
REQ-020 If arrived=1 at that sample, SHALL go to STOP (00/00) and stay there until arrived=0, then go to IDLE.
REQ-021 CROSS SHALL drive 01/01 for exactly CROSS_CYCLES cycles; then STRAIGHT -> FOLLOW with turn_done, LEFT -> SPIN with 10/01, RIGHT -> SPIN with 01/10.
REQ-022 SPIN SHALL ignore the sensor for SPIN_MIN_CYCLES cycles, then leave on the first cycle with line_sensor[1]=1, going to FOLLOW with turn_done=1 for that single cycle.
REQ-023 A node edge seen during CROSS or SPIN SHALL be ignored.
REQ-024 enable=0 in any state except FAULT SHALL force IDLE next cycle, clear counters and drive motors 00/00.
REQ-025 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap; a zero parameter means the phase lasts 0 cycles.

Reset
REQ-026 On reset=1 at a clock edge: state IDLE, motor_l=00, motor_r=00, busy=0, turn_done=0, fault=0, counters 0, latched direction 11.
REQ-027 Reset mid-CROSS or mid-SPIN SHALL abort the manoeuvre with no turn_done pulse.

Configuration
REQ-028 With TURN_TIMEOUT_EN defined: if SPIN lasts TIMEOUT_CYCLES cycles without a valid exit, SHALL go to FAULT (00/00, fault=1) and stay there until reset, ignoring enable.
REQ-029 Without TURN_TIMEOUT_EN: no timeout counter, fault tied 0, SPIN is unbounded.

Structure
REQ-030 Package turn_pkg SHALL hold the direction encodings (LEFT/RIGHT/STRAIGHT), the motor command encodings and the state enum.
REQ-031 Sub-module node_edge_detect SHALL register the 111 compare and emit a one-cycle node pulse.

Verification (bench params CROSS=4, SPIN_MIN=3, TIMEOUT=20)
REQ-032 Steering: enable=1, line_sensor 010 then 110 then 000 -> 01/01, then 00/01, then 00/01 held.
REQ-033 Straight node: 111 with turn_direction=11 -> CROSS 01/01 for 4 cycles, then FOLLOW, turn_done=1 for one cycle, busy low.
REQ-034 Left turn: 111 with dir=01, sensor 000 during spin, 010 at spin cycle 5 -> 10/01 throughout SPIN, exit on cycle 5, turn_done pulse; 010 at spin cycle 2 must not cause exit.
REQ-035 Arrival: node with arrived=1 -> STOP 00/00 held; arrived drops -> IDLE then FOLLOW.
REQ-036 Timeout (macro on): RIGHT spin, sensor 000 for 20 cycles -> FAULT, fault=1, motors 00/00, held through enable toggling until reset.
REQ-037 Abort: enable=0 or reset mid-SPIN -> IDLE next cycle, motors 00/00, no turn_done.

Source files
------------

// File: rtl/turn_pkg.sv
// turn_pkg: direction/motor encodings, FSM state enum and counter sizing helper.
package turn_pkg;
  localparam logic [1:0] DIR_LEFT = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_STRAIGHT = 2'b11;
  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD = 2'b01;
  localparam logic [1:0] M_REV = 2'b10;
  typedef enum logic [2:0] {IDLE, FOLLOW, CROSS, SPIN, STOP, FAULT} state_t;
  function automatic int cw(input int n);
    return n < 1 ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/node_edge_detect.sv
// node_edge_detect: registered all-sensors-on compare, one-cycle pulse on its rising edge.
module node_edge_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] line_sensor,
  output logic       node
);
  logic all_on;
  always_ff @(posedge clk) begin
    if (reset) begin
      all_on <= 1'b0;
      node <= 1'b0;
    end else begin
      all_on <= &line_sensor;
      node <= &line_sensor & ~all_on;
    end
  end
endmodule

// File: rtl/turn_executor.sv
// turn_executor: line follower with node crossing and spin turns; TURN_TIMEOUT_EN adds a spin timeout fault.
module turn_executor
  import turn_pkg::*;
#(
  parameter int CROSS_CYCLES = 5000,
  parameter int SPIN_MIN_CYCLES = 2000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] line_sensor,
  input  logic [1:0] turn_direction,
  input  logic       arrived,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       busy,
  output logic       turn_done,
  output logic       fault
);
  localparam int CW_A = cw(CROSS_CYCLES) > cw(SPIN_MIN_CYCLES) ? cw(CROSS_CYCLES) : cw(SPIN_MIN_CYCLES);
`ifdef TURN_TIMEOUT_EN
  localparam int CW = CW_A > cw(TIMEOUT_CYCLES) ? CW_A : cw(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] S_LIM = T_LAST;
`else
  localparam int CW = CW_A;
  localparam logic [CW-1:0] S_LIM = CW'(SPIN_MIN_CYCLES);
`endif
  localparam logic [CW-1:0] C_LAST = CW'(CROSS_CYCLES - 1);
  localparam logic [CW-1:0] S_MIN = CW'(SPIN_MIN_CYCLES);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] dir_q, xd, sl, sr;
  logic node, steer, cross_done, spin_exit, spin_to, turn;
  node_edge_detect u_node (
    .clk(clk),
    .reset(reset),
    .line_sensor(line_sensor),
    .node(node)
  );
  assign steer = line_sensor inside {3'b010, 3'b100, 3'b110, 3'b001, 3'b011};
  assign sl = line_sensor[2] ? M_STOP : M_FWD;
  assign sr = line_sensor[0] ? M_STOP : M_FWD;
  // zero-length crossing resolves the turn on the node edge itself
  assign cross_done = state == CROSS ? cnt == C_LAST
                    : state == FOLLOW && node && !arrived && CROSS_CYCLES == 0;
  assign xd = state == CROSS ? dir_q : turn_direction;
  assign turn = ^xd;
  assign spin_exit = cnt >= S_MIN && line_sensor[1];
`ifdef TURN_TIMEOUT_EN
  assign spin_to = TIMEOUT_CYCLES == 0 || cnt == T_LAST;
  always_ff @(posedge clk) fault <= !reset && (fault || (state == SPIN && enable && !spin_exit && spin_to));
`else
  assign spin_to = 1'b0;
  assign fault = 1'b0;
`endif
  always_ff @(posedge clk) begin
    turn_done <= 1'b0;
    if (reset || (!enable && state != FAULT)) begin
      state <= IDLE;
      motor_l <= M_STOP;
      motor_r <= M_STOP;
      busy <= 1'b0;
      cnt <= '0;
      if (reset) dir_q <= DIR_STRAIGHT;
    end else if (cross_done) begin
      dir_q <= xd;
      cnt <= '0;
      state <= turn ? SPIN : FOLLOW;
      motor_l <= xd == DIR_LEFT ? M_REV : M_FWD;
      motor_r <= xd == DIR_RIGHT ? M_REV : M_FWD;
      busy <= turn;
      turn_done <= !turn;
    end else begin
      case (state)
        IDLE: state <= FOLLOW;
        FOLLOW:
          if (node) begin
            dir_q <= turn_direction;
            state <= arrived ? STOP : CROSS;
            motor_l <= arrived ? M_STOP : M_FWD;
            motor_r <= arrived ? M_STOP : M_FWD;
            busy <= !arrived;
            cnt <= '0;
          end else if (steer) begin
            motor_l <= sl;
            motor_r <= sr;
          end
        CROSS: cnt <= cnt + 1'b1;
        SPIN:
          if (spin_exit) begin
            state <= FOLLOW;
            motor_l <= M_FWD;
            motor_r <= M_FWD;
            busy <= 1'b0;
            turn_done <= 1'b1;
            cnt <= '0;
          end else if (spin_to) begin
            state <= FAULT;
            motor_l <= M_STOP;
            motor_r <= M_STOP;
            busy <= 1'b0;
          end else if (cnt < S_LIM) begin
            cnt <= cnt + 1'b1;
          end
        STOP: if (!arrived) state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_turn_executor.sv
// tb_turn_executor: steering table, hand-written node/turn/abort sequences, randomized run against a phase model.
module tb_turn_executor;
  localparam int CC = 4;
  localparam int SM = 3;
  localparam int TO = 20;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, enable, arrived, busy, turn_done, fault;
  logic [2:0] line_sensor;
  logic [1:0] turn_direction, motor_l, motor_r;
  int passed = 0;
  int total = 0;

  turn_executor #(.CROSS_CYCLES(CC), .SPIN_MIN_CYCLES(SM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .line_sensor(line_sensor),
    .turn_direction(turn_direction), .arrived(arrived), .motor_l(motor_l),
    .motor_r(motor_r), .busy(busy), .turn_done(turn_done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [1:0] l;
    logic [1:0] r;
  } steer_t;
  steer_t tbl[8];

  function automatic logic [6:0] pk(input logic [1:0] l, input logic [1:0] r, input logic b, input logic t, input logic f);
    return {l, r, b, t, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {motor_l, motor_r, busy, turn_done, fault};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got ml=%b mr=%b busy=%b td=%b fault=%b, expected ml=%b mr=%b busy=%b td=%b fault=%b",
                  name, act[6:5], act[4:3], act[2], act[1], act[0], exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic node_go(input logic [1:0] d, input logic a, input logic [2:0] post);
    line_sensor = 3'b111;
    turn_direction = d;
    arrived = a;
    tick();
    line_sensor = post;
    tick();
  endtask

  // phase model: 0 idle, 1 follow, 2 cross, 3 spin, 4 stop, 5 fault
  int ph, cleft, sage;
  logic [1:0] ml, mr, md;
  bit mb, mt, mf, last7, mnode;

  task automatic mstep();
    bit nd;
    nd = mnode;
    mnode = line_sensor == 3'b111 && !last7;
    last7 = line_sensor == 3'b111;
    mt = 0;
    if (reset) begin
      ph = 0; ml = 0; mr = 0; mb = 0; mf = 0; md = 3; mnode = 0; last7 = 0;
    end else if (!enable && ph != 5) begin
      ph = 0; ml = 0; mr = 0; mb = 0;
    end else begin
      case (ph)
        0: ph = 1;
        1:
          if (nd) begin
            md = turn_direction;
            if (arrived) begin ph = 4; ml = 0; mr = 0; end
            else begin ph = 2; cleft = CC; ml = 1; mr = 1; mb = 1; end
          end else if (line_sensor == 3'b010) begin ml = 1; mr = 1; end
          else if (line_sensor == 3'b100 || line_sensor == 3'b110) begin ml = 0; mr = 1; end
          else if (line_sensor == 3'b001 || line_sensor == 3'b011) begin ml = 1; mr = 0; end
        2: begin
          cleft--;
          if (cleft == 0) begin
            if (md == 2'b01) begin ph = 3; sage = 0; ml = 2; mr = 1; end
            else if (md == 2'b10) begin ph = 3; sage = 0; ml = 1; mr = 2; end
            else begin ph = 1; mb = 0; mt = 1; end
          end
        end
        3: begin
          sage++;
          if (sage > SM && line_sensor[1]) begin ph = 1; ml = 1; mr = 1; mb = 0; mt = 1; end
          else if (TO_EN && sage >= TO) begin ph = 5; ml = 0; mr = 0; mb = 0; mf = 1; end
        end
        4: if (!arrived) ph = 0;
        default: ;
      endcase
    end
  endtask

  initial begin
    tbl[0] = '{3'b010, 2'b01, 2'b01};
    tbl[1] = '{3'b110, 2'b00, 2'b01};
    tbl[2] = '{3'b000, 2'b00, 2'b01};
    tbl[3] = '{3'b100, 2'b00, 2'b01};
    tbl[4] = '{3'b001, 2'b01, 2'b00};
    tbl[5] = '{3'b011, 2'b01, 2'b00};
    tbl[6] = '{3'b101, 2'b01, 2'b00};
    tbl[7] = '{3'b010, 2'b01, 2'b01};
    reset = 1; enable = 0; arrived = 0; line_sensor = 3'b000; turn_direction = 2'b11;
    tick(); tick();
    chk("reset", pk(0, 0, 0, 0, 0));
    reset = 0;
    tick();
    chk("idle_disabled", pk(0, 0, 0, 0, 0));
    enable = 1;
    tick();
    chk("enter_follow", pk(0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      line_sensor = tbl[i].s;
      tick();
      chk($sformatf("steer%0d_%b", i, tbl[i].s), pk(tbl[i].l, tbl[i].r, 0, 0, 0));
    end
    // straight node
    line_sensor = 3'b111; turn_direction = 2'b11; arrived = 0;
    tick();
    chk("node_hold", pk(1, 1, 0, 0, 0));
    line_sensor = 3'b010;
    tick();
    for (int i = 0; i < CC; i++) begin
      if (i > 0) tick();
      chk($sformatf("cross%0d", i), pk(1, 1, 1, 0, 0));
    end
    tick();
    chk("straight_done", pk(1, 1, 0, 1, 0));
    tick();
    chk("straight_td_once", pk(1, 1, 0, 0, 0));
    // left turn with early line hits ignored
    node_go(2'b01, 0, 3'b000);
    repeat (CC) tick();
    chk("left_spin1", pk(2, 1, 1, 0, 0));
    tick();
    chk("left_spin2", pk(2, 1, 1, 0, 0));
    line_sensor = 3'b010;
    tick();
    chk("left_spin3_ignored", pk(2, 1, 1, 0, 0));
    tick();
    chk("left_spin4_ignored", pk(2, 1, 1, 0, 0));
    line_sensor = 3'b000;
    tick();
    chk("left_spin5", pk(2, 1, 1, 0, 0));
    line_sensor = 3'b010;
    tick();
    chk("left_exit", pk(1, 1, 0, 1, 0));
    tick();
    chk("left_td_once", pk(1, 1, 0, 0, 0));
    // arrival
    node_go(2'b11, 1, 3'b010);
    chk("stop", pk(0, 0, 0, 0, 0));
    tick();
    chk("stop_hold", pk(0, 0, 0, 0, 0));
    arrived = 0;
    tick();
    chk("stop_to_idle", pk(0, 0, 0, 0, 0));
    tick();
    chk("idle_to_follow", pk(0, 0, 0, 0, 0));
    tick();
    chk("arrival_resume", pk(1, 1, 0, 0, 0));
    // enable abort mid-spin
    node_go(2'b10, 0, 3'b000);
    repeat (CC) tick();
    chk("right_spin1", pk(1, 2, 1, 0, 0));
    tick();
    enable = 0;
    tick();
    chk("enable_abort", pk(0, 0, 0, 0, 0));
    tick();
    chk("enable_abort_hold", pk(0, 0, 0, 0, 0));
    enable = 1; line_sensor = 3'b010;
    tick();
    chk("enable_reentry", pk(0, 0, 0, 0, 0));
    tick();
    chk("enable_no_td", pk(1, 1, 0, 0, 0));
    // reset abort mid-spin
    node_go(2'b01, 0, 3'b000);
    repeat (CC) tick();
    chk("reset_spin1", pk(2, 1, 1, 0, 0));
    tick();
    reset = 1;
    tick();
    chk("reset_abort", pk(0, 0, 0, 0, 0));
    reset = 0; line_sensor = 3'b010;
    tick();
    chk("reset_reentry", pk(0, 0, 0, 0, 0));
    tick();
    chk("reset_no_td", pk(1, 1, 0, 0, 0));
    // long spin: timeout or unbounded
    node_go(2'b10, 0, 3'b000);
    repeat (CC) tick();
    chk("long_spin1", pk(1, 2, 1, 0, 0));
`ifdef TURN_TIMEOUT_EN
    repeat (TO - 1) tick();
    chk("spin_last_before_timeout", pk(1, 2, 1, 0, 0));
    tick();
    chk("fault", pk(0, 0, 0, 0, 1));
    enable = 0;
    tick();
    chk("fault_enable_low", pk(0, 0, 0, 0, 1));
    enable = 1; line_sensor = 3'b010;
    tick();
    chk("fault_enable_high", pk(0, 0, 0, 0, 1));
    reset = 1;
    tick();
    chk("fault_cleared", pk(0, 0, 0, 0, 0));
    reset = 0;
`else
    repeat (24) tick();
    chk("spin_unbounded", pk(1, 2, 1, 0, 0));
    line_sensor = 3'b010;
    tick();
    chk("long_spin_exit", pk(1, 1, 0, 1, 0));
`endif
    // randomized run against the phase model
    reset = 1;
    mstep();
    tick();
    chk("rand_reset", pk(ml, mr, mb, mt, mf));
    reset = 0;
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: line_sensor = 3'b010;
        4: line_sensor = 3'b111;
        5: line_sensor = 3'b000;
        default: line_sensor = 3'($urandom_range(0, 7));
      endcase
      turn_direction = 2'($urandom_range(0, 3));
      arrived = $urandom_range(0, 7) == 0;
      enable = $urandom_range(0, 40) != 0;
      reset = $urandom_range(0, 150) == 0;
      mstep();
      tick();
      chk($sformatf("rand%0d", c), pk(ml, mr, mb, mt, mf));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
